count_register: RTL and testbench

//   Loadable down-counter used as the ASIP loop/element counter.
//   - Datapath loads an element count, then decrements it once per processed item.
//   - zero_flag tells the control unit when the loop is exhausted.
//   - Single clock domain; sits beside the ALU/accumulator registers.

---
 rtl/count_register.sv | 51 +++++
 tb/tb_count_register.sv | 133 +++++++++++++
 2 files changed

// File: rtl/count_register.sv
// Loadable down-counter for the ASIP loop/element count, with a synchronous active-high reset.
// Optional macro COUNT_REG_WRAP_EN: decrementing at zero wraps to all-ones instead of holding at zero.
module count_register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] Count_in,
  input  logic             Count_load,
  input  logic             Count_dec,
  output logic [WIDTH-1:0] Count_out,
  output logic             zero_flag
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             is_zero;

  assign is_zero = (count_q == '0);

  // Next count: load beats decrement, and decrement beats hold.
  always_comb begin
    count_d = count_q;
    if (Count_load) begin
      count_d = Count_in;
    end else if (Count_dec) begin
      if (!is_zero) begin
        count_d = count_q - WIDTH'(1);
      end else begin
`ifdef COUNT_REG_WRAP_EN
        count_d = '1;
`else
        count_d = count_q;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count_out = count_q;
  // The flag is decoded from the count register, so it adds no extra cycle of delay.
  assign zero_flag = is_zero;

endmodule

// File: tb/tb_count_register.sv
// Self-checking bench for count_register: directed cases followed by random strobes checked against an integer model.
`timescale 1ns/1ps
module tb_count_register;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_load;
  logic             cnt_dec;
  logic [WIDTH-1:0] cnt_out;
  logic             zflag;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned model;

  count_register #(.WIDTH(WIDTH)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .Count_in   (cnt_in),
    .Count_load (cnt_load),
    .Count_dec  (cnt_dec),
    .Count_out  (cnt_out),
    .zero_flag  (zflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Expected result of decrementing a count that is already zero.
  function automatic int unsigned underflow_value();
`ifdef COUNT_REG_WRAP_EN
    return MAXV;
`else
    return 0;
`endif
  endfunction

  // Apply one edge of inputs, advance the model, and sample just after the edge.
  task automatic step(input logic r, input logic ld, input logic dc, input int unsigned din);
    @(negedge clk);
    rst = r; cnt_load = ld; cnt_dec = dc; cnt_in = WIDTH'(din);
    @(posedge clk);
    if (r)            model = 0;
    else if (ld)      model = din & MAXV;
    else if (dc)      model = (model == 0) ? underflow_value() : model - 1;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(cnt_out), model);
    check({tag, ".zero"},  32'(zflag), (model == 0) ? 1 : 0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; model = 0;
    rst = 1'b0; cnt_load = 1'b0; cnt_dec = 1'b0; cnt_in = '0;

    // Reset wins over a simultaneous load.
    step(1'b1, 1'b1, 1'b0, 5);
    check("reset.count", 32'(cnt_out), 0);
    check("reset.zero",  32'(zflag), 1);

    // Load 5 and count down to zero with dec held high.
    step(1'b0, 1'b1, 1'b0, 5);
    check("load5.count", 32'(cnt_out), 5);
    check("load5.zero",  32'(zflag), 0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      check("down.count", 32'(cnt_out), 32'(5 - i));
      check("down.zero",  32'(zflag), (i == 5) ? 1 : 0);
    end

    // One further decrement at zero.
    step(1'b0, 1'b0, 1'b1, 0);
    check("underflow.count", 32'(cnt_out), underflow_value());
    check("underflow.zero",  32'(zflag), (underflow_value() == 0) ? 1 : 0);

    // Load of 0 beats a simultaneous decrement.
    step(1'b0, 1'b1, 1'b0, 3);
    step(1'b0, 1'b1, 1'b1, 0);
    check("prio.count", 32'(cnt_out), 0);
    check("prio.zero",  32'(zflag), 1);

    // Reset in the middle of a count, then load all-ones and decrement.
    step(1'b0, 1'b1, 1'b0, 4);
    step(1'b1, 1'b0, 1'b1, 0);
    check("midrst.count", 32'(cnt_out), 0);
    step(1'b0, 1'b1, 1'b0, MAXV);
    check("loadmax.count", 32'(cnt_out), MAXV);
    check("loadmax.zero",  32'(zflag), 0);
    step(1'b0, 1'b0, 1'b1, 0);
    check("decmax.count", 32'(cnt_out), MAXV - 1);

    // Hold for three edges with no strobes.
    step(1'b0, 1'b1, 1'b0, 7);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, $urandom_range(MAXV, 0));
      check("hold.count", 32'(cnt_out), 7);
      check("hold.zero",  32'(zflag), 0);
    end

    // Random strobes; small loads keep the count near zero so underflow is exercised.
    for (int i = 0; i < 400; i++) begin
      logic        r, ld, dc;
      int unsigned din;
      r  = ($urandom_range(31, 0) == 0);
      ld = ($urandom_range(5, 0) == 0);
      dc = ($urandom_range(1, 0) == 1);
      case ($urandom_range(3, 0))
        0:       din = 0;
        1:       din = MAXV;
        2:       din = $urandom_range(4, 1);
        default: din = $urandom_range(MAXV, 0);
      endcase
      step(r, ld, dc, din);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
